neuron_sequencer: RTL and testbench

Control stage directly upstream of the MAC. On a start pulse it clears the MAC accumulator, streams exactly N_INPUTS operand pairs into it through a valid/ready input handshake, then reads back the accumulated sum. It adds an optional bias, rescales and saturates the result, and presents one neuron output through a valid/ready output handshake.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/neuron_sequencer_if.sv | 52 +++++
 rtl/neuron_postproc.sv | 31 +++
 rtl/neuron_sequencer.sv | 132 +++++++++++++
 tb/tb_neuron_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron sequencer slice:
//   - state_t   : sequencer FSM state encoding (IDLE, CLEAR, FEED, DRAIN, OUT)
//   - DEF_*     : default widths and pair count used as parameter defaults
//   - cnt_width : width of the pair counter, $clog2(n_inputs+1)
// Optional build macro used by files importing this package:
//   NEURON_SEQ_BIAS_EN
// ---------------------------------------------------------------------------
package neuron_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ACC_WIDTH  = 18;
   localparam int DEF_OUT_WIDTH  = 8;
   localparam int DEF_N_INPUTS   = 16;
   localparam int DEF_SHIFT      = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   // Counter wide enough to hold every value 0..n_inputs.
   function automatic int cnt_width(input int n_inputs);
      return $clog2(n_inputs + 1);
   endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// ---------------------------------------------------------------------------
// neuron_sequencer_if
// Bundles the control, operand, MAC-side and output signals of the neuron
// sequencer.
//   slave  : the sequencer itself
//   master : the environment (upstream source, MAC, downstream sink)
// Handshake rule for both in_* and out_* channels: a transfer happens on a
// rising clock edge where valid and ready are both high; the producer holds
// valid and its data stable until that edge, and ready never depends on
// anything that would create a combinational loop back to valid.
// bias exists only when NEURON_SEQ_BIAS_EN is defined.
// ---------------------------------------------------------------------------
interface neuron_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 18,
   parameter int OUT_WIDTH  = 8
);
   logic                  start;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH:0]   in_b;
`ifdef NEURON_SEQ_BIAS_EN
   logic [ACC_WIDTH-1:0]  bias;
`endif
   logic                  mac_rst;
   logic                  mac_en;
   logic [DATA_WIDTH-1:0] mac_a;
   logic [DATA_WIDTH:0]   mac_b;
   logic [ACC_WIDTH-1:0]  mac_result;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_WIDTH-1:0]  out_data;

   modport slave (
`ifdef NEURON_SEQ_BIAS_EN
      input  bias,
`endif
      input  start, in_valid, in_a, in_b, mac_result, out_ready,
      output busy, in_ready, mac_rst, mac_en, mac_a, mac_b, out_valid, out_data
   );

   modport master (
`ifdef NEURON_SEQ_BIAS_EN
      output bias,
`endif
      output start, in_valid, in_a, in_b, mac_result, out_ready,
      input  busy, in_ready, mac_rst, mac_en, mac_a, mac_b, out_valid, out_data
   );

endinterface

// File: rtl/neuron_postproc.sv
// ---------------------------------------------------------------------------
// neuron_postproc
// Combinational post-processing of the accumulated sum:
//   sum = i_mac_result + i_bias (ACC_WIDTH+1 bits, cannot overflow)
//   scaled = sum >> SHIFT
//   o_data = min(scaled, 2^OUT_WIDTH-1)
// Ports:
//   i_mac_result  ACC_WIDTH   accumulator value
//   i_bias        ACC_WIDTH   unsigned bias (tied to zero when unused)
//   o_data        OUT_WIDTH   saturated result
// ---------------------------------------------------------------------------
module neuron_postproc #(
   parameter int ACC_WIDTH = 18,
   parameter int SHIFT     = 4,
   parameter int OUT_WIDTH = 8
)(
   input  logic [ACC_WIDTH-1:0] i_mac_result,
   input  logic [ACC_WIDTH-1:0] i_bias,
   output logic [OUT_WIDTH-1:0] o_data
);
   localparam logic [ACC_WIDTH:0] SAT_MAX =
      {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   logic [ACC_WIDTH:0] w_sum;
   logic [ACC_WIDTH:0] w_scaled;

   assign w_sum    = {1'b0, i_mac_result} + {1'b0, i_bias};
   assign w_scaled = w_sum >> SHIFT;
   assign o_data   = (w_scaled > SAT_MAX) ? {OUT_WIDTH{1'b1}} : w_scaled[OUT_WIDTH-1:0];

endmodule

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
// Control stage in front of a MAC. On start: one CLEAR cycle (mac_rst), then
// N_INPUTS operand pairs are streamed to the MAC, one DRAIN cycle computes the
// bias-added, shifted, saturated output, and OUT presents it until accepted.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   sif          neuron_sequencer_if.slave (start/busy, in_*, mac_*, out_*)
//   o_dbg_state  current FSM state for observation
// Build option: NEURON_SEQ_BIAS_EN adds the bias input and its capture register.
// ---------------------------------------------------------------------------
module neuron_sequencer
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int N_INPUTS   = DEF_N_INPUTS,
   parameter int SHIFT      = DEF_SHIFT,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH
)(
   input  logic               clk,
   input  logic               rst,
   neuron_sequencer_if.slave  sif,
   output state_t             o_dbg_state
);
   localparam int CNT_W = cnt_width(N_INPUTS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_busy;
   logic                 r_in_ready;
   logic                 r_mac_rst;
   logic                 r_out_valid;
   logic [OUT_WIDTH-1:0] r_out_data;

   logic                 w_accept;
   logic [ACC_WIDTH-1:0] w_bias;
   logic [OUT_WIDTH-1:0] w_post;

`ifdef NEURON_SEQ_BIAS_EN
   logic [ACC_WIDTH-1:0] r_bias;
   assign w_bias = r_bias;
`else
   assign w_bias = '0;
`endif

   assign w_accept = sif.in_valid & r_in_ready;

   // Operands reach the MAC only while FEED is accepting pairs.
   assign sif.mac_en    = w_accept;
   assign sif.mac_a     = r_in_ready ? sif.in_a : '0;
   assign sif.mac_b     = r_in_ready ? sif.in_b : '0;
   assign sif.mac_rst   = r_mac_rst;
   assign sif.in_ready  = r_in_ready;
   assign sif.busy      = r_busy;
   assign sif.out_valid = r_out_valid;
   assign sif.out_data  = r_out_data;
   assign o_dbg_state   = r_state;

   neuron_postproc #(
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_postproc (
      .i_mac_result (sif.mac_result),
      .i_bias       (w_bias),
      .o_data       (w_post)
   );

   // Flags are registered alongside the state so each one is a clean decode
   // of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_mac_rst   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
`ifdef NEURON_SEQ_BIAS_EN
         r_bias      <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (sif.start) begin
                  r_state   <= ST_CLEAR;
                  r_busy    <= 1'b1;
                  r_mac_rst <= 1'b1;
`ifdef NEURON_SEQ_BIAS_EN
                  r_bias    <= sif.bias;
`endif
               end
            end
            ST_CLEAR: begin
               r_mac_rst  <= 1'b0;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
               r_state    <= ST_FEED;
            end
            ST_FEED: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_IDX) begin
                     r_in_ready <= 1'b0;
                     r_state    <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // mac_result already holds the final accumulate here.
               r_out_data  <= w_post;
               r_out_valid <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (sif.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_sequencer
// Directed bench for neuron_sequencer with N_INPUTS=4, SHIFT=4, a behavioural
// MAC model and an expected-output queue. Works in both builds
// (NEURON_SEQ_BIAS_EN defined or not).
// ---------------------------------------------------------------------------
module tb_neuron_sequencer;
   import neuron_pkg::*;

   localparam int DW = 8;
   localparam int AW = 18;
   localparam int OW = 8;
   localparam int NI = 4;
   localparam int SH = 4;

   // Pairs (1,2),(3,4),(5,6),(7,8) sum to 100.
`ifdef NEURON_SEQ_BIAS_EN
   localparam logic [OW-1:0] EXP_BASIC = 8'd10;  // (100+60)>>4
`else
   localparam logic [OW-1:0] EXP_BASIC = 8'd6;   // 100>>4
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   state_t dbg_state;
   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int c0     = 0;
   int n_xfer = 0;
   int n_bad_en = 0;
   logic [OW-1:0] exp_q[$];
   logic [AW-1:0] mac_acc = '0;
   logic          force_sat = 1'b0;

   neuron_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) sif();

   neuron_sequencer #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .N_INPUTS   (NI),
      .SHIFT      (SH),
      .OUT_WIDTH  (OW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sif         (sif),
      .o_dbg_state (dbg_state)
   );

   // MAC model: synchronous clear, registered accumulate.
   always @(posedge clk) begin
      if (sif.mac_rst)
         mac_acc <= '0;
      else if (sif.mac_en)
         mac_acc <= mac_acc + (AW'(sif.mac_a) * AW'(sif.mac_b));
   end
   assign sif.mac_result = force_sat ? 18'h3FFFF : mac_acc;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (sif.out_valid && sif.out_ready) n_xfer <= n_xfer + 1;
   always @(negedge clk) if (sif.mac_en && !sif.in_valid) n_bad_en <= n_bad_en + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Start is sampled at the edge after which c0 is recorded (edge 0).
   task automatic do_start(input logic [AW-1:0] b);
      @(posedge clk); #1;
      sif.start = 1'b1;
`ifdef NEURON_SEQ_BIAS_EN
      sif.bias = b;
`endif
      @(posedge clk); #1;
      sif.start = 1'b0;
      c0 = cyc;
`ifdef NEURON_SEQ_BIAS_EN
      sif.bias = '1;  // must not matter after capture
`else
      if (b != '0) sif.in_a = '0;
`endif
   endtask

   task automatic feed_pair(input logic [DW-1:0] a, input logic [DW:0] b);
      logic acc;
      sif.in_valid = 1'b1;
      sif.in_a = a;
      sif.in_b = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = sif.in_ready;
         @(posedge clk); #1;
         if (acc) return;
      end
      check("feed_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_pairs(input int stall);
      for (int p = 0; p < NI; p++) begin
         feed_pair(DW'(2 * p + 1), (DW + 1)'(2 * p + 2));
         if (p == 1 && stall > 0) begin
            sif.in_valid = 1'b0;
            repeat (stall) @(posedge clk);
            #1;
         end
      end
      sif.in_valid = 1'b0;
   endtask

   // Latency in cycles, counting the CLEAR cycle as 1.
   task automatic wait_out(output int lat);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sif.out_valid) begin
            lat = cyc - c0 + 1;
            return;
         end
      end
      lat = -1;
      check("out_timeout", 32'd0, 32'd1);
   endtask

   task automatic take_out(input string tag);
      logic [OW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check({tag, "_data"}, 32'(sif.out_data), 32'(e));
      sif.out_ready = 1'b1;
      @(posedge clk); #1;
      sif.out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int xfer0;
      sif.start = 1'b0;
      sif.in_valid = 1'b0;
      sif.in_a = '0;
      sif.in_b = '0;
      sif.out_ready = 1'b0;
`ifdef NEURON_SEQ_BIAS_EN
      sif.bias = '0;
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(sif.busy), 32'd0);
      check("rst_in_ready", 32'(sif.in_ready), 32'd0);
      check("rst_out_valid", 32'(sif.out_valid), 32'd0);
      check("rst_out_data", 32'(sif.out_data), 32'd0);
      check("rst_mac_en", 32'(sif.mac_en), 32'd0);
      check("rst_mac_rst", 32'(sif.mac_rst), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;

      // Operands gated outside FEED
      sif.in_a = 8'h55;
      sif.in_b = 9'h1AA;
      @(negedge clk);
      check("idle_mac_a", 32'(sif.mac_a), 32'd0);
      check("idle_mac_b", 32'(sif.mac_b), 32'd0);
      sif.in_a = '0;
      sif.in_b = '0;

      // Basic back-to-back run
      exp_q.push_back(EXP_BASIC);
      do_start(18'd60);
      check("clr_state", 32'(dbg_state), 32'(ST_CLEAR));
      check("clr_mac_rst", 32'(sif.mac_rst), 32'd1);
      check("clr_busy", 32'(sif.busy), 32'd1);
      check("clr_in_ready", 32'(sif.in_ready), 32'd0);
      run_pairs(0);
      wait_out(lat);
      check("basic_latency", 32'(lat), 32'd7);
      take_out("basic");

      // Stall of 3 cycles between pairs 2 and 3
      exp_q.push_back(EXP_BASIC);
      do_start(18'd60);
      run_pairs(3);
      wait_out(lat);
      check("stall_latency", 32'(lat), 32'd10);
      take_out("stall");
      check("stall_mac_en_no_valid", 32'(n_bad_en), 32'd0);

      // Saturation: 0x3FFFF >> 4 = 16383 -> 255
      force_sat = 1'b1;
      exp_q.push_back(8'd255);
      do_start(18'd0);
      run_pairs(0);
      wait_out(lat);
      check("sat_latency", 32'(lat), 32'd7);
      take_out("sat");
      force_sat = 1'b0;

      // Backpressure with an ignored start during OUT
      xfer0 = n_xfer;
      exp_q.push_back(EXP_BASIC);
      do_start(18'd60);
      run_pairs(0);
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(sif.out_valid), 32'd1);
         check("bp_out_data", 32'(sif.out_data), 32'(EXP_BASIC));
         @(posedge clk); #1;
         sif.start = (i == 1);
         @(negedge clk);
      end
      sif.start = 1'b0;
      check("bp_state_out", 32'(dbg_state), 32'(ST_OUT));
      take_out("bp");
      check("bp_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("bp_busy_low", 32'(sif.busy), 32'd0);
      check("bp_out_valid_low", 32'(sif.out_valid), 32'd0);
      @(posedge clk); #1;
      check("bp_no_queued_start", 32'(dbg_state), 32'(ST_IDLE));
      check("bp_one_transfer", 32'(n_xfer - xfer0), 32'd1);

      // Reset mid-FEED after two accepts
      do_start(18'd60);
      feed_pair(8'd1, 9'd2);
      feed_pair(8'd3, 9'd4);
      sif.in_valid = 1'b1;
      sif.in_a = 8'd5;
      sif.in_b = 9'd6;
      #1;
      check("feed_mac_a", 32'(sif.mac_a), 32'd5);
      check("feed_mac_b", 32'(sif.mac_b), 32'd6);
      check("feed_mac_en", 32'(sif.mac_en), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("mid_rst_in_ready", 32'(sif.in_ready), 32'd0);
      check("mid_rst_mac_en", 32'(sif.mac_en), 32'd0);
      check("mid_rst_busy", 32'(sif.busy), 32'd0);
      check("mid_rst_mac_a", 32'(sif.mac_a), 32'd0);
      check("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
      sif.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(EXP_BASIC);
      do_start(18'd60);
      check("rerun_clear", 32'(dbg_state), 32'(ST_CLEAR));
      run_pairs(0);
      wait_out(lat);
      check("rerun_latency", 32'(lat), 32'd7);
      take_out("rerun");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
